// File: rtl/matvec_core_p.sv
// matvec_core_p: streams in a DIM x DIM matrix and a vector, computes y = W*x one MAC per
// cycle, and streams the DIM results out with backpressure and a last marker.
module matvec_core_p #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int DIM        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_signed,
    input  logic                  cfg_accum,
    input  logic                  snk_vld,
    output logic                  snk_rdy,
    input  logic [DATA_WIDTH-1:0] snk_data,
    output logic                  src_vld,
    input  logic                  src_rdy,
    output logic [ACC_WIDTH-1:0]  src_data,
    output logic                  src_last,
    output logic                  busy
);
    localparam int CW = $clog2(DIM * DIM);
    localparam int XW = $clog2(DIM);
    localparam logic [CW-1:0] LW = CW'(DIM * DIM - 1);
    localparam logic [CW-1:0] LX = CW'(DIM - 1);

    typedef enum logic [1:0] {LOAD_W, LOAD_X, COMPUTE, FLUSH} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt, nxt;
    logic [XW-1:0]           row, col;
    logic                    sgn, accm, take;
    logic [DATA_WIDTH-1:0]   w [DIM*DIM];
    logic [DATA_WIDTH-1:0]   x [DIM];
    logic [ACC_WIDTH-1:0]    acc [DIM];
    logic [ACC_WIDTH-1:0]    prod, base;

    function automatic logic [ACC_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] v, input logic s);
        return s ? {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v} : ACC_WIDTH'(v);
    endfunction

    assign snk_rdy = (state == LOAD_W) || (state == LOAD_X);
    assign take    = snk_vld && snk_rdy;
    assign nxt     = cnt + CW'(1);
    assign row     = XW'(cnt / DIM);
    assign col     = XW'(cnt % DIM);
    assign prod    = ext(w[cnt], sgn) * ext(x[col], sgn);
    assign base    = (col == '0 && !accm) ? '0 : acc[row];

    // Operand storage carries no reset: a new run always overwrites it before use.
    always_ff @(posedge clk) begin
        if (take && state == LOAD_W) w[cnt] <= snk_data;
        if (take && state == LOAD_X) x[XW'(cnt)] <= snk_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD_W;
            cnt      <= '0;
            sgn      <= 1'b0;
            accm     <= 1'b0;
            src_vld  <= 1'b0;
            src_data <= '0;
            src_last <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < DIM; i++) acc[i] <= '0;
        end else begin
            case (state)
                LOAD_W: if (take) begin
                    if (cnt == '0) begin
                        sgn  <= cfg_signed;
                        accm <= cfg_accum;
                    end
                    cnt   <= (cnt == LW) ? '0 : nxt;
                    state <= (cnt == LW) ? LOAD_X : LOAD_W;
                    busy  <= 1'b1;
                end
                LOAD_X: if (take) begin
                    cnt   <= (cnt == LX) ? '0 : nxt;
                    state <= (cnt == LX) ? COMPUTE : LOAD_X;
                end
                COMPUTE: begin
                    acc[row] <= base + prod;
                    cnt      <= (cnt == LW) ? '0 : nxt;
                    if (cnt == LW) begin
                        state    <= FLUSH;
                        src_vld  <= 1'b1;
                        src_data <= acc[0];
                        src_last <= 1'b0;
                    end
                end
                FLUSH: if (src_rdy) begin
                    if (cnt == LX) begin
                        state    <= LOAD_W;
                        cnt      <= '0;
                        src_vld  <= 1'b0;
                        src_last <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        cnt      <= nxt;
                        src_data <= acc[XW'(nxt)];
                        src_last <= (nxt == LX);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matvec_core_p.sv
// tb_matvec_core_p: drives a 32-bit and a 16-bit accumulator core with shared stimulus
// and checks both against an arithmetic model of y = W*x.
module tb_matvec_core_p;
    localparam int N = 4;

    typedef struct {
        logic [31:0] d32;
        logic [15:0] d16;
        logic        last;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_signed = 1'b0, cfg_accum = 1'b0, snk_vld = 1'b0, src_rdy = 1'b0;
    logic [7:0]  snk_data = '0;
    logic        a_snk_rdy, a_src_vld, a_src_last, a_busy;
    logic        b_snk_rdy, b_src_vld, b_src_last, b_busy;
    logic [31:0] a_src_data;
    logic [15:0] b_src_data;

    int          checks = 0, errors = 0;
    logic [7:0]  wv [N*N];
    logic [7:0]  xv [N];
    logic [31:0] m32 [N];
    logic [15:0] m16 [N];
    logic [31:0] got32 [N];
    logic [15:0] got16 [N];
    exp_t        q [$];
    bit          pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    matvec_core_p #(.DATA_WIDTH(8), .ACC_WIDTH(32), .DIM(N)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed), .cfg_accum(cfg_accum),
        .snk_vld(snk_vld), .snk_rdy(a_snk_rdy), .snk_data(snk_data),
        .src_vld(a_src_vld), .src_rdy(src_rdy), .src_data(a_src_data),
        .src_last(a_src_last), .busy(a_busy));

    matvec_core_p #(.DATA_WIDTH(8), .ACC_WIDTH(16), .DIM(N)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed), .cfg_accum(cfg_accum),
        .snk_vld(snk_vld), .snk_rdy(b_snk_rdy), .snk_data(snk_data),
        .src_vld(b_src_vld), .src_rdy(src_rdy), .src_data(b_src_data),
        .src_last(b_src_last), .busy(b_busy));

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic longint ext(input logic [7:0] v, input bit sg);
        return sg ? longint'($signed(v)) : longint'({56'd0, v});
    endfunction

    function automatic bit rdy(input int mode, input int i);
        return (mode == 0) ? 1'b1 : (mode == 1) ? pat[i % 7] : ($urandom_range(0, 3) != 0);
    endfunction

    // Whole-run result per row, folded onto the previous run's values when accumulating.
    task automatic model(input bit sg, input bit ac);
        for (int r = 0; r < N; r++) begin
            longint s = 0;
            for (int c = 0; c < N; c++) s += ext(wv[r*N+c], sg) * ext(xv[c], sg);
            m32[r] = (ac ? m32[r] : 32'd0) + 32'(s);
            m16[r] = (ac ? m16[r] : 16'd0) + 16'(s);
            q.push_back('{m32[r], m16[r], r == N - 1});
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        chk("vld_match", b_src_vld, a_src_vld);
        if (a_src_vld) begin
            chk("pending", q.size() > 0, 1);
            if (q.size() > 0) begin
                chk("data32", a_src_data, q[0].d32);
                chk("data16", b_src_data, q[0].d16);
                chk("last32", a_src_last, q[0].last);
                chk("last16", b_src_last, q[0].last);
                if (src_rdy) void'(q.pop_front());
            end
        end
    end

    task automatic beat(input logic [7:0] d);
        if ($urandom_range(0, 3) == 0) begin
            snk_vld = 1'b0;
            @(posedge clk); #1;
        end
        snk_data = d;
        snk_vld  = 1'b1;
        @(negedge clk);
        chk("snk_rdy_load", a_snk_rdy, 1);
        @(posedge clk); #1;
    endtask

    task automatic run(input bit sg, input bit ac, input int mode);
        int lat, i, hs;
        model(sg, ac);
        cfg_signed = sg;
        cfg_accum  = ac;
        for (int k = 0; k < N*N; k++) begin
            beat(wv[k]);
            if (k == 0) begin
                chk("busy_loading", a_busy, 1);
                cfg_signed = 1'($urandom);
                cfg_accum  = 1'($urandom);
            end
        end
        for (int k = 0; k < N; k++) beat(xv[k]);
        snk_data = 8'($urandom);
        src_rdy  = rdy(mode, 0);
        chk("snk_rdy_compute", a_snk_rdy, 0);
        lat = 0;
        while (!a_src_vld && lat < 64) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk("latency", lat, N*N);
        i  = 0;
        hs = 0;
        while (hs < N && i < 64) begin
            if (a_src_vld && src_rdy) begin
                got32[hs] = a_src_data;
                got16[hs] = b_src_data;
                hs++;
            end
            @(posedge clk); #1;
            i++;
            src_rdy = rdy(mode, i);
            if (hs < N) @(negedge clk);
        end
        chk("flush_beats", hs, N);
        snk_vld = 1'b0;
        @(negedge clk);
        chk("vld_after", a_src_vld, 0);
        chk("snk_rdy_after", a_snk_rdy, 1);
        chk("busy_after", a_busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic abort_mid();
        cfg_signed = 1'b0;
        cfg_accum  = 1'b0;
        for (int k = 0; k < N*N; k++) beat(wv[k]);
        for (int k = 0; k < N; k++) beat(xv[k]);
        snk_vld = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("abort_busy", a_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_vld", a_src_vld, 0);
        chk("abort_snk_rdy", a_snk_rdy, 1);
        chk("abort_busy_clr", a_busy, 0);
        chk("abort_busy16", b_busy, 0);
        q.delete();
        for (int r = 0; r < N; r++) begin
            m32[r] = '0;
            m16[r] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic ident();
        for (int k = 0; k < N*N; k++) wv[k] = (k / N == k % N) ? 8'd1 : 8'd0;
        for (int k = 0; k < N; k++) xv[k] = 8'(k + 1);
    endtask

    task automatic fill(input logic [7:0] wval, input logic [7:0] xval);
        for (int k = 0; k < N*N; k++) wv[k] = wval;
        for (int k = 0; k < N; k++) xv[k] = xval;
    endtask

    task automatic lit_ramp(input string nm, input int k);
        for (int i = 0; i < N; i++) begin
            chk(nm, got32[i], (i + 1) * k);
            chk(nm, got16[i], (i + 1) * k);
        end
    endtask

    task automatic lit_const(input string nm, input longint v32, input longint v16);
        for (int i = 0; i < N; i++) begin
            chk(nm, got32[i], v32);
            chk(nm, got16[i], v16);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < N; r++) begin
            m32[r] = '0;
            m16[r] = '0;
        end
        #12;
        chk("rst_snk_rdy", a_snk_rdy, 1);
        chk("rst_src_vld", a_src_vld, 0);
        chk("rst_src_data", a_src_data, 0);
        chk("rst_src_data16", b_src_data, 0);
        chk("rst_src_last", a_src_last, 0);
        chk("rst_busy", a_busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        ident();
        run(1'b0, 1'b0, 0);
        lit_ramp("identity", 1);
        run(1'b0, 1'b1, 1);
        lit_ramp("accum", 2);
        run(1'b0, 1'b0, 1);
        lit_ramp("accum_clear", 1);

        fill(8'hFF, 8'h02);
        run(1'b1, 1'b0, 2);
        lit_const("signed", 32'hFFFF_FFF8, 16'hFFF8);
        run(1'b0, 1'b0, 0);
        lit_const("unsigned", 2040, 2040);

        fill(8'hFF, 8'hFF);
        run(1'b0, 1'b0, 2);
        lit_const("wrap", 260100, 63492);

        ident();
        abort_mid();
        ident();
        run(1'b0, 1'b1, 0);
        lit_ramp("after_reset", 1);

        repeat (20) begin
            for (int k = 0; k < N*N; k++) wv[k] = 8'($urandom);
            for (int k = 0; k < N; k++) xv[k] = 8'($urandom);
            run(1'($urandom), 1'($urandom), 2);
        end
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
